ps2_key_tracker: RTL and testbench

- Sits between the PS/2 byte receiver and the player-movement/keyboard control logic.
- Consumes raw scan-code bytes (set 2) and decodes the make, break (F0), extended (E0) and pause (E1) sequences.
- Keeps a held-state bitmap of the 12 game actions for both players, plus one-cycle press pulses for one-shot actions (throw, jump).
- Typematic repeats are absorbed here, so downstream logic sees clean level and edge information.

---
 rtl/ps2_key_tracker_pkg.sv | 54 +++++
 rtl/ps2_code_lookup.sv | 32 +++
 rtl/ps2_key_tracker.sv | 140 ++++++++++++++
 tb/tb_ps2_key_tracker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_tracker_pkg.sv
// Shared scan-code map, action-bit indices and tracker FSM encoding.
// Imported by the key tracker and by the downstream keyboard control block.
package key_map_pkg;

  localparam int NUM_ACT = 12;

  // Action-bit indices into held/press
  localparam int ACT_LP_LEFT       = 0;
  localparam int ACT_LP_RIGHT      = 1;
  localparam int ACT_LP_SWORD_UP   = 2;
  localparam int ACT_LP_SWORD_DOWN = 3;
  localparam int ACT_LP_THROW      = 4;
  localparam int ACT_LP_JUMP       = 5;
  localparam int ACT_RP_LEFT       = 6;
  localparam int ACT_RP_RIGHT      = 7;
  localparam int ACT_RP_SWORD_UP   = 8;
  localparam int ACT_RP_SWORD_DOWN = 9;
  localparam int ACT_RP_JUMP       = 10;
  localparam int ACT_RP_THROW      = 11;

  // Set-2 scan codes (the RP direction codes are only valid after E0)
  localparam logic [7:0] SC_LP_LEFT       = 8'h1C;
  localparam logic [7:0] SC_LP_RIGHT      = 8'h23;
  localparam logic [7:0] SC_LP_SWORD_UP   = 8'h1D;
  localparam logic [7:0] SC_LP_SWORD_DOWN = 8'h1B;
  localparam logic [7:0] SC_LP_THROW      = 8'h12;
  localparam logic [7:0] SC_SPACE         = 8'h29;
  localparam logic [7:0] SC_RP_LEFT       = 8'h6B;
  localparam logic [7:0] SC_RP_RIGHT      = 8'h74;
  localparam logic [7:0] SC_RP_SWORD_UP   = 8'h75;
  localparam logic [7:0] SC_RP_SWORD_DOWN = 8'h72;
  localparam logic [7:0] SC_RP_THROW      = 8'h5A;

  // Prefix bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  // Tracker FSM encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXT     = 3'd1;
  localparam logic [2:0] ST_BRK     = 3'd2;
  localparam logic [2:0] ST_EXT_BRK = 3'd3;
  localparam logic [2:0] ST_SKIP    = 3'd4;

  // Bytes remaining in a Pause sequence after its leading E1
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  // True for any byte that opens or continues a prefix sequence
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK) || (b == SC_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_code_lookup.sv
// Combinational {extended, code} -> action mask. Space maps to both jump bits.
module ps2_code_lookup
  import key_map_pkg::*;
(
  input  logic               i_ext,
  input  logic [7:0]         i_code,
  output logic [NUM_ACT-1:0] o_mask
);

  // Decode the extended flag and code together so E0-qualified keys stay distinct
  always_comb begin
    o_mask = '0;
    case ({i_ext, i_code})
      {1'b0, SC_LP_LEFT}:       o_mask[ACT_LP_LEFT]       = 1'b1;
      {1'b0, SC_LP_RIGHT}:      o_mask[ACT_LP_RIGHT]      = 1'b1;
      {1'b0, SC_LP_SWORD_UP}:   o_mask[ACT_LP_SWORD_UP]   = 1'b1;
      {1'b0, SC_LP_SWORD_DOWN}: o_mask[ACT_LP_SWORD_DOWN] = 1'b1;
      {1'b0, SC_LP_THROW}:      o_mask[ACT_LP_THROW]      = 1'b1;
      {1'b0, SC_SPACE}: begin
        o_mask[ACT_LP_JUMP] = 1'b1;
        o_mask[ACT_RP_JUMP] = 1'b1;
      end
      {1'b0, SC_RP_THROW}:      o_mask[ACT_RP_THROW]      = 1'b1;
      {1'b1, SC_RP_LEFT}:       o_mask[ACT_RP_LEFT]       = 1'b1;
      {1'b1, SC_RP_RIGHT}:      o_mask[ACT_RP_RIGHT]      = 1'b1;
      {1'b1, SC_RP_SWORD_UP}:   o_mask[ACT_RP_SWORD_UP]   = 1'b1;
      {1'b1, SC_RP_SWORD_DOWN}: o_mask[ACT_RP_SWORD_DOWN] = 1'b1;
      default:                  o_mask = '0;
    endcase
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code tracker: decodes make/break/extended/pause sequences
// into a held-key bitmap with press pulses, and abandons stale prefixes.
module ps2_key_tracker
  import key_map_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 2_000_000
)(
  input  logic               clk_50MHz,
  input  logic               rst,
  input  logic [7:0]         rx_byte,
  input  logic               rx_valid,
  input  logic               clr,
  output logic [NUM_ACT-1:0] held,
  output logic [NUM_ACT-1:0] press,
  output logic               seq_err
);

  localparam int CNT_W = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_skip;
  logic [NUM_ACT-1:0] r_held;
  logic [NUM_ACT-1:0] r_press;
  logic               r_seq_err;

  logic [2:0]         w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [2:0]         w_skip_nxt;
  logic [NUM_ACT-1:0] w_held_nxt;
  logic               w_err_nxt;
  logic               w_ext;
  logic [NUM_ACT-1:0] w_mask;

  assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);

  ps2_code_lookup u_lookup (
    .i_ext  (w_ext),
    .i_code (rx_byte),
    .o_mask (w_mask)
  );

  // Next-state decode: clr beats a byte, a byte beats the prefix timeout
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_skip_nxt  = r_skip;
    w_held_nxt  = r_held;
    w_err_nxt   = 1'b0;
    if (clr) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_skip_nxt  = '0;
      w_held_nxt  = '0;
    end else if (rx_valid) begin
      w_cnt_nxt = '0;
      case (r_state)
        ST_IDLE: begin
          if (rx_byte == SC_EXT) begin
            w_state_nxt = ST_EXT;
          end else if (rx_byte == SC_BRK) begin
            w_state_nxt = ST_BRK;
          end else if (rx_byte == SC_PAUSE) begin
            w_state_nxt = ST_SKIP;
            w_skip_nxt  = PAUSE_TAIL;
          end else begin
            w_held_nxt = r_held | w_mask;
          end
        end
        ST_EXT: begin
          if (rx_byte == SC_BRK) begin
            w_state_nxt = ST_EXT_BRK;
          end else if (is_prefix(rx_byte)) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_held_nxt  = r_held | w_mask;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          w_state_nxt = ST_IDLE;
          if (is_prefix(rx_byte)) begin
            w_err_nxt = 1'b1;
          end else begin
            w_held_nxt = r_held & ~w_mask;
          end
        end
        ST_SKIP: begin
          if (r_skip <= 3'd1) begin
            w_state_nxt = ST_IDLE;
            w_skip_nxt  = '0;
          end else begin
            w_skip_nxt = r_skip - 3'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_skip_nxt  = '0;
        end
      endcase
    end else if (r_state != ST_IDLE) begin
      if (r_cnt == CNT_LAST) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_skip_nxt  = '0;
        w_err_nxt   = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else begin
      w_cnt_nxt = '0;
    end
  end

  // Register FSM, counters, held bitmap and the one-cycle pulses
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_skip    <= '0;
      r_held    <= '0;
      r_press   <= '0;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_skip    <= w_skip_nxt;
      r_held    <= w_held_nxt;
      r_press   <= w_held_nxt & ~r_held;
      r_seq_err <= w_err_nxt;
    end
  end

  assign held    = r_held;
  assign press   = r_press;
  assign seq_err = r_seq_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed vector table, hand-written corner
// sequences and randomized traffic against a byte-history reference model.
module tb_ps2_key_tracker;

  localparam int T = 20;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        clr = 1'b0;
  logic [11:0] held;
  logic [11:0] press;
  logic        seq_err;

  int checks = 0;
  int errors = 0;

  ps2_key_tracker #(.PREFIX_TIMEOUT(T)) dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .clr       (clr),
    .held      (held),
    .press     (press),
    .seq_err   (seq_err)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // ---------------- reference model ----------------
  logic [11:0] keymap [0:511];
  logic [7:0]  pend [$];
  int          m_skip;
  int          m_idle;
  logic [11:0] m_held, m_press;
  logic        m_err;

  function automatic bit pfx(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
  endfunction

  task automatic model_reset();
    pend.delete();
    m_skip = 0; m_idle = 0;
    m_held = '0; m_press = '0; m_err = 1'b0;
  endtask

  task automatic model_cycle(input logic v, input logic [7:0] b, input logic c);
    logic [11:0] old;
    old = m_held;
    m_err = 1'b0;
    if (c) begin
      pend.delete(); m_skip = 0; m_idle = 0; m_held = '0;
    end else if (v) begin
      m_idle = 0;
      if (m_skip > 0) begin
        m_skip--;
      end else begin
        pend.push_back(b);
        if (pend.size() == 1) begin
          if (b == 8'hE1) begin m_skip = 7; pend.delete(); end
          else if (b != 8'hE0 && b != 8'hF0) begin
            m_held |= keymap[{1'b0, b}]; pend.delete();
          end
        end else if (pend.size() == 2 && pend[0] == 8'hE0) begin
          if (b == 8'hF0) begin end
          else if (pfx(b)) begin m_err = 1'b1; pend.delete(); end
          else begin m_held |= keymap[{1'b1, b}]; pend.delete(); end
        end else if (pend.size() == 2) begin
          if (pfx(b)) m_err = 1'b1;
          else m_held &= ~keymap[{1'b0, b}];
          pend.delete();
        end else begin
          if (pfx(b)) m_err = 1'b1;
          else m_held &= ~keymap[{1'b1, b}];
          pend.delete();
        end
      end
    end else if (pend.size() > 0 || m_skip > 0) begin
      m_idle++;
      if (m_idle == T) begin
        m_err = 1'b1; pend.delete(); m_skip = 0; m_idle = 0;
      end
    end
    m_press = m_held & ~old;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic c);
    @(negedge clk_50MHz);
    rx_valid = v; rx_byte = b; clr = c;
    model_cycle(v, b, c);
    @(posedge clk_50MHz);
    #1;
    chk("model_held", 32'(held), 32'(m_held));
    chk("model_press", 32'(press), 32'(m_press));
    chk("model_err", 32'(seq_err), 32'(m_err));
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        c;
    logic [11:0] eh;
    logic [11:0] ep;
    logic        ee;
  } vec_t;

  vec_t tbl [$];
  logic [7:0] pause_seq [8];
  logic [7:0] pool [15];

  initial begin
    typedef struct { bit ext; logic [7:0] code; int bitn; } ent_t;
    ent_t ents [12];
    ents = '{'{1'b0, 8'h1C, 0}, '{1'b0, 8'h23, 1}, '{1'b0, 8'h1D, 2},
             '{1'b0, 8'h1B, 3}, '{1'b0, 8'h12, 4}, '{1'b0, 8'h29, 5},
             '{1'b1, 8'h6B, 6}, '{1'b1, 8'h74, 7}, '{1'b1, 8'h75, 8},
             '{1'b1, 8'h72, 9}, '{1'b0, 8'h29, 10}, '{1'b0, 8'h5A, 11}};
    for (int i = 0; i < 512; i++) keymap[i] = '0;
    for (int i = 0; i < 12; i++) keymap[{ents[i].ext, ents[i].code}][ents[i].bitn] = 1'b1;
    model_reset();

    // Reset state
    #35;
    chk("reset_held", 32'(held), 0);
    chk("reset_press", 32'(press), 0);
    chk("reset_err", 32'(seq_err), 0);
    @(negedge clk_50MHz);
    rst = 1'b0;

    // Directed vectors: one row per clock
    tbl.push_back('{1'b1, 8'h1C, 1'b0, 12'h001, 12'h001, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 12'h001, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 8'hF0, 1'b0, 12'h001, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 8'h1C, 1'b0, 12'h000, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 8'hE0, 1'b0, 12'h000, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 8'h6B, 1'b0, 12'h040, 12'h040, 1'b0});
    tbl.push_back('{1'b1, 8'h6B, 1'b0, 12'h040, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 8'hE0, 1'b0, 12'h040, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 8'hF0, 1'b0, 12'h040, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 8'h6B, 1'b0, 12'h000, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 8'h29, 1'b0, 12'h420, 12'h420, 1'b0});
    tbl.push_back('{1'b1, 8'h29, 1'b0, 12'h420, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 8'hE0, 1'b0, 12'h420, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 8'h5A, 1'b0, 12'h420, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 8'h5A, 1'b0, 12'hC20, 12'h800, 1'b0});
    tbl.push_back('{1'b1, 8'hE0, 1'b0, 12'hC20, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 8'hE0, 1'b0, 12'hC20, 12'h000, 1'b1});
    tbl.push_back('{1'b1, 8'hF0, 1'b0, 12'hC20, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 8'hE1, 1'b0, 12'hC20, 12'h000, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 12'hC20, 12'h000, 1'b0});
    tbl.push_back('{1'b1, 8'h1C, 1'b1, 12'h000, 12'h000, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].b, tbl[i].c);
      chk($sformatf("vec%0d_held", i), 32'(held), 32'(tbl[i].eh));
      chk($sformatf("vec%0d_press", i), 32'(press), 32'(tbl[i].ep));
      chk($sformatf("vec%0d_err", i), 32'(seq_err), 32'(tbl[i].ee));
    end

    // Space held down with typematic repeats: one press only
    step(1'b1, 8'h29, 1'b0);
    chk("space_press", 32'(press), 32'h420);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h29, 1'b0);
      chk("space_repeat_press", 32'(press), 0);
    end
    chk("space_repeat_held", 32'(held), 32'h420);
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'h29, 1'b0);
    chk("space_release", 32'(held), 0);

    // Stale E0 prefix times out, then 74 is a plain (unmapped) make
    step(1'b1, 8'hE0, 1'b0);
    for (int i = 1; i <= T; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk("timeout_err", 32'(seq_err), (i == T) ? 1 : 0);
    end
    step(1'b0, 8'h00, 1'b0);
    chk("timeout_single_pulse", 32'(seq_err), 0);
    step(1'b1, 8'h74, 1'b0);
    chk("after_timeout_bit7", 32'(held[7]), 0);

    // Pause sequence is swallowed silently
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pause_seq[i], 1'b0);
      chk("pause_err", 32'(seq_err), 0);
      chk("pause_held", 32'(held), 0);
    end
    step(1'b1, 8'h23, 1'b0);
    chk("after_pause_bit1", 32'(held[1]), 1);

    // clr wins over a simultaneous F0; the next byte is a make
    step(1'b1, 8'h1C, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    chk("pre_clr_held", 32'(held), 32'h803);
    step(1'b1, 8'hF0, 1'b1);
    chk("clr_held", 32'(held), 0);
    chk("clr_press", 32'(press), 0);
    step(1'b1, 8'h1C, 1'b0);
    chk("post_clr_make", 32'(held), 32'h001);
    chk("post_clr_press", 32'(press), 32'h001);

    // Async reset in the middle of an extended sequence
    step(1'b1, 8'h23, 1'b0);
    step(1'b1, 8'hE0, 1'b0);
    @(negedge clk_50MHz);
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_held", 32'(held), 0);
    chk("async_rst_press", 32'(press), 0);
    chk("async_rst_err", 32'(seq_err), 0);
    @(negedge clk_50MHz);
    rst = 1'b0;
    model_reset();
    step(1'b1, 8'h6B, 1'b0);
    chk("after_rst_not_ext", 32'(held), 0);

    // Randomized traffic against the model
    pool = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h12, 8'h29, 8'h6B, 8'h74,
             8'h75, 8'h72, 8'h5A, 8'hE0, 8'hF0, 8'hE1, 8'h00};
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      b = pool[$urandom_range(0, 14)];
      if (b == 8'h00) b = 8'($urandom);
      if (r < 2) begin
        step(1'b1, b, 1'b1);
      end else if (r < 50) begin
        step(1'b1, b, 1'b0);
      end else if (r < 52) begin
        for (int k = 0; k < T + 2; k++) step(1'b0, 8'h00, 1'b0);
      end else begin
        step(1'b0, 8'($urandom), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
